// File: rtl/uart_pkg.sv
// Shared UART types and default constants for the receive and transmit stages.
package uart_pkg;

    localparam int UART_BITS_DEFAULT  = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2 clk latency.
// Reset value is a parameter so idle-high lines do not glitch low out of reset.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= RESET_VAL;
            synced <= RESET_VAL;
        end else begin
            meta   <= line;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Oversampled UART receiver: start detect, mid-bit sampling, stop check, one-clk valid/frame_error pulses.
// rx sees 2 clk of synchronizer latency; no backpressure, consumer must capture message on valid.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int UART_BITS_TRANSFERED = UART_BITS_DEFAULT,
    parameter int OVERSAMPLE           = OVERSAMPLE_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            baud_tick,
    input  logic                            rx,
    output logic [UART_BITS_TRANSFERED-1:0] message,
    output logic                            valid,
    output logic                            frame_error,
    output logic                            busy
);

    localparam int TW = $clog2(OVERSAMPLE) + 1;
    localparam int BW = $clog2(UART_BITS_TRANSFERED) + 1;

    rx_state_e                       state, state_next;
    logic [TW-1:0]                   tick_count, tick_count_next;
    logic [BW-1:0]                   bit_idx, bit_idx_next;
    logic [UART_BITS_TRANSFERED-1:0] shift_reg, shift_reg_next;
    logic [UART_BITS_TRANSFERED-1:0] message_next;
    logic                            valid_next, frame_error_next;
    logic                            rx_s;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .line   (rx),
        .synced (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_count  <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            message     <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            tick_count  <= tick_count_next;
            bit_idx     <= bit_idx_next;
            shift_reg   <= shift_reg_next;
            message     <= message_next;
            valid       <= valid_next;
            frame_error <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state;
        tick_count_next  = tick_count;
        bit_idx_next     = bit_idx;
        shift_reg_next   = shift_reg;
        message_next     = message;
        valid_next       = 1'b0;
        frame_error_next = 1'b0;

        if (baud_tick) begin
            case (state)
                IDLE: begin
                    // Half-bit countdown so the start bit is re-checked at its centre.
                    if (!rx_s) begin
                        state_next      = START;
                        tick_count_next = TW'(OVERSAMPLE / 2 - 1);
                    end
                end
                START: begin
                    if (tick_count == '0) begin
                        if (!rx_s) begin
                            state_next      = DATA;
                            tick_count_next = TW'(OVERSAMPLE - 1);
                            bit_idx_next    = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_count_next = tick_count - 1'b1;
                    end
                end
                DATA: begin
                    if (tick_count == '0) begin
                        for (int i = 0; i < UART_BITS_TRANSFERED; i++) begin
                            if (bit_idx == BW'(i)) shift_reg_next[i] = rx_s;
                        end
                        tick_count_next = TW'(OVERSAMPLE - 1);
                        if (bit_idx == BW'(UART_BITS_TRANSFERED - 1)) begin
                            state_next = STOP;
                        end else begin
                            bit_idx_next = bit_idx + 1'b1;
                        end
                    end else begin
                        tick_count_next = tick_count - 1'b1;
                    end
                end
                STOP: begin
                    if (tick_count == '0) begin
                        if (rx_s) begin
                            message_next = shift_reg;
                            valid_next   = 1'b1;
                            state_next   = IDLE;
                        end else begin
                            frame_error_next = 1'b1;
                            state_next       = WAIT_IDLE;
                        end
                    end else begin
                        tick_count_next = tick_count - 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line must go high before another start can be seen.
                    if (rx_s) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
